reg_bank_writer: RTL

- Write side of the ASIP datapath register bank. Accepts a byte from the result bus plus a 3-bit destination code and commits it to one of eight registers: MAX, MIN, R0, COUNT, SUM, PC, IR, TEMP.
- Destination codes use the same encoding as the read-side bus selector.
- Supports plain writes, SUM accumulate, a two-cycle MAX/MIN compare-update, and PC increment / COUNT decrement strobes.
- Exposes all eight registers in parallel to the read-side selector.

---
 rtl/reg_bank_writer_pkg.sv | 15 +
 rtl/reg_bank_writer_reg_cell.sv | 30 +++
 rtl/reg_bank_writer.sv | 101 ++++++++++
 3 files changed

// File: rtl/reg_bank_writer_pkg.sv
// reg_bank_writer_pkg: shared destination codes, op modes and FSM states for the register bank write side
package reg_bank_writer_pkg;
  localparam logic [2:0] DST_MAX   = 3'b000;
  localparam logic [2:0] DST_MIN   = 3'b001;
  localparam logic [2:0] DST_R0    = 3'b010;
  localparam logic [2:0] DST_COUNT = 3'b011;
  localparam logic [2:0] DST_SUM   = 3'b100;
  localparam logic [2:0] DST_PC    = 3'b101;
  localparam logic [2:0] DST_IR    = 3'b110;
  localparam logic [2:0] DST_TEMP  = 3'b111;
  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_ACC = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  typedef enum logic {ST_IDLE, ST_CMP_MIN} state_t;
endpackage

// File: rtl/reg_bank_writer_reg_cell.sv
// reg_bank_writer_reg_cell: DW-bit register with load (highest priority), increment and decrement
// Carries an even-parity bit and mismatch flag when REGBANK_PARITY_EN is defined.
module reg_bank_writer_reg_cell #(
  parameter int DW = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          i_ld,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
`ifdef REGBANK_PARITY_EN
  ,
  input  logic          i_par_inv,
  output logic          o_par_bad
`endif
);
  logic [DW-1:0] r_q;
  logic [DW-1:0] w_nxt;
  assign w_nxt = i_ld ? i_d : i_inc ? r_q + DW'(1) : i_dec ? r_q - DW'(1) : r_q;
  assign o_q = r_q;
  always_ff @(posedge CLK) r_q <= !RST_n ? RST_VAL : w_nxt;
`ifdef REGBANK_PARITY_EN
  logic r_par;
  always_ff @(posedge CLK) r_par <= !RST_n ? ^RST_VAL : (^w_nxt) ^ (i_ld & i_par_inv);
  assign o_par_bad = r_par != ^r_q;
`endif
endmodule

// File: rtl/reg_bank_writer.sv
// reg_bank_writer: write side of the ASIP register bank (plain write, accumulate, MAX/MIN compare, PC/COUNT strobes)
// Optional parity protection with Par_inject/Par_err ports when REGBANK_PARITY_EN is defined.
module reg_bank_writer
  import reg_bank_writer_pkg::*;
#(
  parameter int DW = 8,
  parameter logic [DW-1:0] PC_RST = 8'h00
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [DW-1:0] BUS_in,
  input  logic [2:0]    Dest_sel,
  input  logic [1:0]    Op_mode,
  input  logic          WR_valid,
  output logic          WR_ready,
  input  logic          PC_inc,
  input  logic          COUNT_dec,
  output logic [DW-1:0] MAX_out,
  output logic [DW-1:0] MIN_out,
  output logic [DW-1:0] R0_out,
  output logic [DW-1:0] COUNT_out,
  output logic [DW-1:0] SUM_out,
  output logic [DW-1:0] PC_out,
  output logic [DW-1:0] IR_out,
  output logic [DW-1:0] TEMP_out,
  output logic          SUM_carry,
  output logic          COUNT_zero
`ifdef REGBANK_PARITY_EN
  ,
  input  logic          Par_inject,
  output logic          Par_err
`endif
);
  state_t r_state, w_next;
  logic [DW-1:0] r_hold;
  logic r_carry;
  logic w_acc, w_plain, w_accum, w_cmp, w_in_cmp;
  logic [DW:0] w_sum;
  logic [DW-1:0] w_d [8];
  logic [DW-1:0] w_q [8];
  logic w_ld [8];
  assign WR_ready = r_state == ST_IDLE;
  assign w_acc    = WR_valid && WR_ready;
  assign w_accum  = w_acc && Op_mode == OP_ACC;
  assign w_cmp    = w_acc && Op_mode == OP_CMP;
  assign w_plain  = w_acc && !w_accum && !w_cmp;
  assign w_in_cmp = r_state == ST_CMP_MIN;
  assign w_sum    = {1'b0, w_q[DST_SUM]} + {1'b0, BUS_in};
  assign w_next   = w_cmp ? ST_CMP_MIN : ST_IDLE;
  always_ff @(posedge CLK) begin
    r_state <= !RST_n ? ST_IDLE : w_next;
    r_hold  <= !RST_n ? '0 : w_cmp ? BUS_in : r_hold;
    r_carry <= !RST_n ? 1'b0 : (w_plain && Dest_sel == DST_SUM) ? 1'b0 : r_carry | (w_accum & w_sum[DW]);
  end
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_ld[i] = w_plain && Dest_sel == 3'(i);
      w_d[i]  = BUS_in;
    end
    w_ld[DST_SUM] = w_ld[DST_SUM] || w_accum;
    w_d[DST_SUM]  = w_accum ? w_sum[DW-1:0] : BUS_in;
    w_ld[DST_MAX] = w_ld[DST_MAX] || (w_cmp && BUS_in > w_q[DST_MAX]);
    w_ld[DST_MIN] = w_ld[DST_MIN] || (w_in_cmp && r_hold < w_q[DST_MIN]);
    w_d[DST_MIN]  = w_in_cmp ? r_hold : BUS_in;
  end
`ifdef REGBANK_PARITY_EN
  logic [7:0] w_bad;
  logic r_par_err;
  always_ff @(posedge CLK) r_par_err <= !RST_n ? 1'b0 : r_par_err | (|w_bad);
  assign Par_err = r_par_err;
`endif
  for (genvar g = 0; g < 8; g++) begin : g_cell
    reg_bank_writer_reg_cell #(
      .DW(DW),
      .RST_VAL(3'(g) == DST_PC ? PC_RST : 3'(g) == DST_MIN ? {DW{1'b1}} : '0)
    ) u_cell (
      .CLK(CLK),
      .RST_n(RST_n),
      .i_ld(w_ld[g]),
      .i_inc(3'(g) == DST_PC && PC_inc),
      .i_dec(3'(g) == DST_COUNT && COUNT_dec),
      .i_d(w_d[g]),
      .o_q(w_q[g])
`ifdef REGBANK_PARITY_EN
      ,
      .i_par_inv(Par_inject && w_acc),
      .o_par_bad(w_bad[g])
`endif
    );
  end
  assign MAX_out    = w_q[DST_MAX];
  assign MIN_out    = w_q[DST_MIN];
  assign R0_out     = w_q[DST_R0];
  assign COUNT_out  = w_q[DST_COUNT];
  assign SUM_out    = w_q[DST_SUM];
  assign PC_out     = w_q[DST_PC];
  assign IR_out     = w_q[DST_IR];
  assign TEMP_out   = w_q[DST_TEMP];
  assign SUM_carry  = r_carry;
  assign COUNT_zero = w_q[DST_COUNT] == '0;
endmodule
